// File: rtl/fetch_unit.sv
// Instruction-fetch front end: single-outstanding req/ack engine, prefetch FIFO, IR and PC history.
// A redirect flushes the FIFO; a response to a stale address is absorbed in the drop state.
module fetch_unit #(
    parameter int unsigned    AW       = 8,
    parameter int unsigned    IW       = 17,
    parameter int unsigned    DEPTH    = 4,
    parameter int unsigned    HIST     = 2,
    parameter logic [AW-1:0]  RESET_PC = '0,
    parameter logic [IW-1:0]  NOP      = '0
) (
    input  logic                    main_clk,
    input  logic                    rst,
    output logic                    imem_req,
    output logic [AW-1:0]           imem_addr,
    input  logic                    imem_ack,
    input  logic [IW-1:0]           imem_rdata,
    input  logic                    stall,
    input  logic                    br_take,
    input  logic [AW-1:0]           br_target,
    output logic [IW-1:0]           ir_out,
    output logic                    ir_valid,
    output logic [HIST*AW-1:0]      pc_hist,
    output logic [$clog2(DEPTH):0]  fifo_count
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned EW = AW + IW;

    typedef enum logic [1:0] {StIdle, StReq, StDrop} state_e;

    state_e         state_q, state_d;
    logic [AW-1:0]  fpc_q, fpc_d;
    logic [AW-1:0]  drop_addr_q, drop_addr_d;
    logic [EW-1:0]  fifo_mem_q [DEPTH];
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic [IW-1:0]  ir_q, ir_d;
    logic           ir_valid_q, ir_valid_d;
    logic [AW-1:0]  hist_q [HIST];
    logic [AW-1:0]  hist_d [HIST];
    logic           push, pop;
    logic [EW-1:0]  head;

    assign imem_req   = (state_q != StIdle);
    assign imem_addr  = (state_q == StDrop) ? drop_addr_q : fpc_q;
    assign pop        = ~br_take & ~stall & (count_q != '0);
    assign head       = fifo_mem_q[rd_ptr_q];
    assign ir_out     = ir_q;
    assign ir_valid   = ir_valid_q;
    assign fifo_count = count_q;

    for (genvar k = 0; k < HIST; k++) begin : g_hist
        assign pc_hist[k*AW +: AW] = hist_q[k];
    end

    always_comb begin
        state_d     = state_q;
        fpc_d       = fpc_q;
        drop_addr_d = drop_addr_q;
        push        = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (br_take) fpc_d = br_target;
                if (count_q < CW'(DEPTH)) state_d = StReq;
            end
            StReq: begin
                if (br_take) begin
                    fpc_d = br_target;
                    if (!imem_ack) begin
                        state_d     = StDrop;
                        drop_addr_d = fpc_q;
                    end
                end else if (imem_ack) begin
                    push  = 1'b1;
                    fpc_d = fpc_q + AW'(1);
                    // This push takes the last free slot unless a pop frees one
                    if ((count_q == CW'(DEPTH - 1)) && !pop) state_d = StIdle;
                end
            end
            StDrop: begin
                if (br_take) fpc_d = br_target;
                if (imem_ack) state_d = StReq;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (br_take) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_comb begin
        ir_d       = ir_q;
        ir_valid_d = ir_valid_q;
        hist_d     = hist_q;
        if (br_take || !stall) begin
            for (int k = 1; k < int'(HIST); k++) hist_d[k] = hist_q[k-1];
            ir_d       = NOP;
            ir_valid_d = 1'b0;
            if (pop) begin
                ir_d       = head[IW-1:0];
                ir_valid_d = 1'b1;
                hist_d[0]  = head[EW-1:IW];
            end
        end
    end

    always_ff @(posedge main_clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            fpc_q       <= RESET_PC;
            drop_addr_q <= RESET_PC;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            ir_q        <= NOP;
            ir_valid_q  <= 1'b0;
            for (int k = 0; k < int'(HIST); k++) hist_q[k] <= '0;
        end else begin
            state_q     <= state_d;
            fpc_q       <= fpc_d;
            drop_addr_q <= drop_addr_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            ir_q        <= ir_d;
            ir_valid_q  <= ir_valid_d;
            hist_q      <= hist_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by the pointers and count
    always_ff @(posedge main_clk) begin
        if (push) fifo_mem_q[wr_ptr_q] <= {fpc_q, imem_rdata};
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction-fetch front end for the pipelined core. It replaces the flat PC, PC-1, PC-2 and IR register chain with a request/acknowledge fetch engine that supports variable-latency instruction memory, and adds a prefetch FIFO of configurable depth. It also provides a PC history shift chain of configurable length that follows the IR. It sits between instruction memory and the DOF stage, and takes stall from hazard logic and redirect from branch detection in EX.

## Interface
- AW, 8: instruction address width.
- IW, 17: instruction width.
- DEPTH, 4: prefetch FIFO entries (power of two, ≥2).
- HIST, 2: number of PC history entries that follow the IR (≥1).
- RESET_PC, 0: fetch address after reset.
- NOP, 0: IW-bit instruction inserted as a bubble.

Ports:
- main_clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-low.
- imem_req  out  1  fetch request valid.
- imem_addr  out  AW  fetch address; stable while imem_req=1 and no ack has been seen.
- imem_ack  in  1  response strobe; may assert in the same cycle as imem_req (combinational memory).
- imem_rdata  in  IW  instruction; valid when imem_req & imem_ack.
- stall  in  1  hold IR and history (data hazard stall).
- br_take  in  1  redirect request from EX.
- br_target  in  AW  redirect address.
- ir_out  out  IW  instruction presented to decode.
- ir_valid  out  1  ir_out is a real instruction; 0 means it is a bubble.
- pc_hist  out  HIST*AW  entry 0 (LSBs) is the PC of ir_out; entry k is the value entry 0 held k IR advances earlier.
- fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy (debug/verification).

## Operation
- Fetch PC (fpc) wraps modulo 2^AW.
- Request FSM states:
  - IDLE: imem_req=0.
  - REQ: imem_req=1, imem_addr=fpc at issue.
  - DROP: imem_req=1 on a stale address; its response is discarded.
- FSM transitions:
  - IDLE→REQ when fifo_count<DEPTH.
  - REQ & ack: push {addr, rdata}, fpc+1. Then stay in REQ if count after this cycle is <DEPTH, else go to IDLE.
  - REQ & no ack & br_take → DROP. imem_addr stays on the old address; fpc←br_target.
  - REQ & ack & br_take: response discarded (no push), fpc←br_target, stay in REQ on the new address.
  - DROP & ack → REQ at fpc, no push. DROP & br_take: fpc←br_target, stay in DROP.
- Only one request is outstanding at a time. Space is checked against the registered count, so a push never overflows.
- IR advance happens when stall=0:
  - FIFO non-empty: pop the head into ir_out and entry 0 of pc_hist, ir_valid=1.
  - FIFO empty: ir_out=NOP, ir_valid=0, entry 0 holds its previous value.
  - pc_hist entries k≥1 shift on every advance.
- No bypass: a word pushed this cycle is poppable from the next cycle.
- stall=1: ir_out, ir_valid and pc_hist hold. The FIFO keeps filling.
- br_take=1 (priority over stall):
  - FIFO flushed (count 0).
  - ir_out=NOP, ir_valid=0.
  - pc_hist entry 0 unchanged, then shifts.
  - A pop in the same cycle is cancelled.
- Reset (rst=0 at an edge) takes priority over everything, mid-transaction included:
  - fpc=RESET_PC, FSM=IDLE, FIFO empty.
  - ir_out=NOP, ir_valid=0, pc_hist all 0, imem_req=0.
  - An outstanding response is abandoned. The memory must tolerate a request dropped at reset.

## Timing
- First request: the cycle after rst deasserts, imem_req=1 with imem_addr=RESET_PC.
- Zero-latency memory, no stalls:
  - Push at the end of request cycle t.
  - IR valid after edge t+2.
  - Sustained throughput is 1 instruction per cycle.
- Memory with ack L cycles after req: one instruction per L+1 cycles.
- Redirect at edge E (zero-latency memory):
  - Target requested in cycle E+1.
  - Target in IR after edge E+3, giving two bubble cycles.
- FIFO full with stall=1: imem_req stays 0 until the first pop.
- Outputs are registered except imem_req and imem_addr, which are decoded from FSM and registers only; there is no combinational path from imem_ack.

## Test plan
- Reset, then free-run with zero-latency memory returning rdata=addr: ir_out sequence 0,1,2,… valid from the third edge, and pc_hist entry 1 lags entry 0 by one.
- stall high for 6 cycles, DEPTH=4: fifo_count saturates at 4, imem_req drops, ir_out holds. On release, the next 4 instructions issue back-to-back with no gaps.
- Ack latency 3:
  - br_take to 0x40 one cycle after a request at 0x05 is issued.
  - Required: imem_addr stays 0x05 until its ack, that ack produces no push, the next request is 0x40, and 0x05's data never reaches ir_out.
- br_take with stall=1 and a full FIFO: FIFO cleared and ir_valid=0 on the next edge, and the target arrives as the first valid instruction.
- fpc wrap: br_take to 0xFE with AW=8. Required: requests 0xFE, 0xFF, 0x00, and pc_hist shows the wrap.
- rst asserted while in DROP with an ack pending: all outputs return to reset values on the next edge, and fetch restarts at RESET_PC.
